// File: rtl/cic_pkg.sv
// Shared CIC helpers (used by both the interpolator and the decimator).
//  cic_growth  : register bit growth for an R/N CIC, interpolating or decimating
//  iq_lane_w   : width of one real lane inside a packed I/Q word
//  iq_im_lsb   : LSB index of the imaginary lane (real lane sits at bit 0)
package cic_pkg;

  localparam int NUM_LANES = 2;  // lane 0 = real, lane 1 = imag

  // Interpolator only needs (N-1)*log2(R): zero stuffing removes one factor of R
  // from the R^N integrator gain. The decimator keeps the full N*log2(R).
  function automatic int cic_growth(int r, int n, bit is_interp);
    int lr;
    lr = $clog2(r);
    return is_interp ? (n - 1) * lr : n * lr;
  endfunction

  function automatic int iq_lane_w(int dw);
    return dw / 2;
  endfunction

  function automatic int iq_im_lsb(int dw);
    return dw / 2;
  endfunction

endpackage

// File: rtl/cic_interp_iq_if.sv
// AXI-stream style channel (tdata/tvalid/tready) for packed I/Q samples.
//  master : drives tdata/tvalid, receives tready
//  slave  : receives tdata/tvalid, drives tready
interface cic_interp_iq_if #(
  parameter int DW = 32
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/cic_interp_lane.sv
// One real lane of the CIC interpolator.
//  Comb chain runs at input rate (delays update only on accept), followed by
//  zero stuffing and a pipelined integrator chain at output rate (updates on step).
// Ports:
//  clk_i, reset_i : clock, synchronous active-high reset
//  i_accept       : input sample consumed this cycle (comb delays advance)
//  i_step         : output-rate step (integrators advance)
//  i_phase0       : step is at phase 0 -> feed comb output, else feed zero
//  i_x            : signed input lane sample
//  o_y            : MSB-truncated output of the last integrator
module cic_interp_lane #(
  parameter int LANE_DW = 16,
  parameter int REG_DW  = 18,
  parameter int OUT_LW  = 18,
  parameter int CIC_N   = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               i_accept,
  input  logic               i_step,
  input  logic               i_phase0,
  input  logic [LANE_DW-1:0] i_x,
  output logic [OUT_LW-1:0]  o_y
);

  logic [REG_DW-1:0] w_x;
  logic [REG_DW-1:0] w_u;

  assign w_x = REG_DW'($signed(i_x));

  // Comb stages: c_k = c_{k-1} - d_k, d_k holds the previous accepted c_{k-1}.
  for (genvar k = 0; k < CIC_N; k++) begin : g_comb
    logic [REG_DW-1:0] w_in;
    logic [REG_DW-1:0] w_out;
    logic [REG_DW-1:0] r_d;

    if (k == 0) begin : g_first
      assign w_in = w_x;
    end else begin : g_next
      assign w_in = g_comb[k-1].w_out;
    end

    assign w_out = w_in - r_d;

    always_ff @(posedge clk_i) begin
      if (reset_i)       r_d <= '0;
      else if (i_accept) r_d <= w_in;
    end
  end

  // Zero stuffing: only the phase-0 step carries the new comb value.
  assign w_u = i_phase0 ? g_comb[CIC_N-1].w_out : '0;

  // Integrators are registered stage to stage, so each adds one step of latency.
  // Arithmetic wraps modulo 2^REG_DW by design.
  for (genvar k = 0; k < CIC_N; k++) begin : g_int
    logic [REG_DW-1:0] w_add;
    logic [REG_DW-1:0] r_acc;

    if (k == 0) begin : g_first
      assign w_add = w_u;
    end else begin : g_next
      assign w_add = g_int[k-1].r_acc;
    end

    always_ff @(posedge clk_i) begin
      if (reset_i)     r_acc <= '0;
      else if (i_step) r_acc <= r_acc + w_add;
    end
  end

  assign o_y = g_int[CIC_N-1].r_acc[REG_DW-1 -: OUT_LW];

endmodule

// File: rtl/cic_interp_iq.sv
// Complex CIC interpolator: upsamples packed I/Q by CIC_R with CIC_N comb and
// CIC_N integrator stages (differential delay 1). Full AXI-stream backpressure.
// Ports:
//  clk_i      : clock
//  reset_i    : synchronous active-high reset
//  s_axis_in  : input I/Q stream (slave), {imag, real} signed lanes
//  m_axis_out : output I/Q stream (master), same packing, OUT_DW wide
module cic_interp_iq
  import cic_pkg::*;
#(
  parameter int IN_DW  = 32,
  parameter int OUT_DW = 36,
  parameter int CIC_R  = 2,
  parameter int CIC_N  = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  cic_interp_iq_if.slave   s_axis_in,
  cic_interp_iq_if.master  m_axis_out
);

  localparam int LANE_DW = iq_lane_w(IN_DW);
  localparam int GROWTH  = cic_growth(CIC_R, CIC_N, 1'b1);
  localparam int REG_DW  = LANE_DW + GROWTH;
  localparam int OUT_LW  = iq_lane_w(OUT_DW);
  localparam int PH_W    = $clog2(CIC_R);

  logic [PH_W-1:0] r_phase;
  logic            r_m_valid;
  logic            w_ph0;
  logic            w_adv;
  logic            w_step;
  logic            w_accept;
  logic [NUM_LANES-1:0][OUT_LW-1:0] w_lane_out;

  assign w_ph0 = (r_phase == '0);
  // Output slot is free when empty or being drained this cycle.
  assign w_adv = !r_m_valid | m_axis_out.tready;
  // At phase 0 a step needs a new sample; otherwise zero-stuffed steps run freely.
  assign w_step   = (!w_ph0 | s_axis_in.tvalid) & w_adv & !reset_i;
  assign w_accept = w_step & w_ph0;

  assign s_axis_in.tready = w_ph0 & w_adv & !reset_i;

  // CIC_R is a power of two, so the counter wraps naturally.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_phase   <= '0;
      r_m_valid <= 1'b0;
    end else if (w_step) begin
      r_phase   <= r_phase + 1'b1;
      r_m_valid <= 1'b1;
    end else if (m_axis_out.tready) begin
      r_m_valid <= 1'b0;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    cic_interp_lane #(
      .LANE_DW (LANE_DW),
      .REG_DW  (REG_DW),
      .OUT_LW  (OUT_LW),
      .CIC_N   (CIC_N)
    ) u_lane (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .i_accept (w_accept),
      .i_step   (w_step),
      .i_phase0 (w_ph0),
      .i_x      (s_axis_in.tdata[l*iq_im_lsb(IN_DW) +: LANE_DW]),
      .o_y      (w_lane_out[l])
    );
  end

  assign m_axis_out.tdata  = w_lane_out;
  assign m_axis_out.tvalid = r_m_valid;

endmodule

// File: tb/tb_cic_interp_iq.sv
module tb_cic_interp_iq;
  localparam int IN_DW  = 32;
  localparam int OUT_DW = 36;
  localparam int R      = 2;
  localparam int N      = 3;
  localparam int LW     = IN_DW / 2;
  localparam int REG_DW = LW + (N - 1) * $clog2(R);
  localparam int OLW    = OUT_DW / 2;
  localparam int HLEN   = N * (R - 1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cic_interp_iq_if #(.DW(IN_DW))  s_if ();
  cic_interp_iq_if #(.DW(OUT_DW)) m_if ();

  cic_interp_iq #(.IN_DW(IN_DW), .OUT_DW(OUT_DW), .CIC_R(R), .CIC_N(N)) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .s_axis_in  (s_if),
    .m_axis_out (m_if)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint h [HLEN];
  int     x_re [$];
  int     x_im [$];
  longint obs_re [$];
  longint obs_im [$];
  int     n_beats = 0;
  int     bp_mode = 0;
  bit     stall = 1'b0;
  logic [OUT_DW-1:0] stall_dat;

  task automatic chk(string tag, longint obs, longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: zero-stuffed input convolved with (1+..+z^-(R-1))^N,
  // delayed by the N-1 integrator pipeline steps, wrapped to REG_DW, MSB slice.
  function automatic longint exp_lane(int j, bit im);
    longint acc;
    int m;
    logic [63:0] a64;
    logic [REG_DW-1:0] t;
    logic signed [OLW-1:0] o;
    acc = 0;
    for (int k = 0; k < HLEN; k++) begin
      m = j - (N - 1) - k;
      if (m >= 0 && (m % R) == 0 && (m / R) < x_re.size())
        acc += h[k] * longint'(im ? x_im[m/R] : x_re[m/R]);
    end
    a64 = acc;
    t = a64[REG_DW-1:0];
    o = t[REG_DW-1 -: OLW];
    return longint'(o);
  endfunction

  function automatic logic [IN_DW-1:0] gen(int kind, int i);
    logic [LW-1:0] re, im;
    case (kind)
      0: begin re = (i == 0) ? LW'(1) : '0; im = '0; end
      1: begin re = LW'(1000); im = LW'(-1000); end
      2: begin re = LW'(-32768); im = LW'(-32768); end
      default: begin re = LW'($urandom); im = LW'($urandom); end
    endcase
    return {im, re};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_vld", longint'(m_if.tvalid), 1);
        chk("hold_dat", longint'(m_if.tdata), longint'(stall_dat));
      end
      if (s_if.tready)
        chk("rdy_ph0", (n_beats + int'(m_if.tvalid)) % R, 0);
      if (s_if.tvalid && s_if.tready) begin
        x_re.push_back(int'($signed(s_if.tdata[LW-1:0])));
        x_im.push_back(int'($signed(s_if.tdata[IN_DW-1:LW])));
      end
      if (m_if.tvalid && m_if.tready) begin
        obs_re.push_back(longint'($signed(m_if.tdata[OLW-1:0])));
        obs_im.push_back(longint'($signed(m_if.tdata[OUT_DW-1:OLW])));
        chk("out_re", obs_re[$], exp_lane(n_beats, 1'b0));
        chk("out_im", obs_im[$], exp_lane(n_beats, 1'b1));
        n_beats++;
      end
      stall = m_if.tvalid && !m_if.tready;
      stall_dat = m_if.tdata;
    end
  end

  // Downstream ready: always 1, or 50% random under backpressure tests
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = (bp_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic clr_model();
    x_re.delete(); x_im.delete(); obs_re.delete(); obs_im.delete();
    n_beats = 0;
  endtask

  task automatic run(string nm, int n, int kind, int gap, int bp);
    int target, guard;
    bit acc;
    bp_mode = bp;
    target = n_beats + n * R;
    for (int i = 0; i < n; i++) begin
      s_if.tvalid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      s_if.tdata  = gen(kind, i);
      s_if.tvalid = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        acc = s_if.tvalid && s_if.tready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) chk({nm, "_acc_timeout"}, 0, 1);
    end
    s_if.tvalid = 1'b0;
    guard = 0;
    while (n_beats < target && guard < 2000) begin @(posedge clk); guard++; end
    #1;
    chk({nm, "_beats"}, n_beats, target);
    bp_mode = 0;
  endtask

  task automatic chk_imp(string nm, int base);
    chk({nm, "_h0"}, obs_re[base+2], 1);
    chk({nm, "_h1"}, obs_re[base+3], 3);
    chk({nm, "_h2"}, obs_re[base+4], 3);
    chk({nm, "_h3"}, obs_re[base+5], 1);
    chk({nm, "_tail"}, obs_re[base+6], 0);
  endtask

  initial begin
    int base;
    for (int k = 0; k < HLEN; k++) h[k] = 0;
    h[0] = 1;
    for (int s = 0; s < N; s++)
      for (int k = HLEN - 1; k >= 0; k--) begin
        longint acc;
        acc = 0;
        for (int r = 0; r < R; r++) if (k - r >= 0) acc += h[k-r];
        h[k] = acc;
      end

    // Reset with input pending: nothing may be accepted or emitted
    rst = 1'b1;
    s_if.tvalid = 1'b1;
    s_if.tdata  = gen(3, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", longint'(s_if.tready), 0);
    chk("rst_vld", longint'(m_if.tvalid), 0);
    chk("rst_dat", longint'(m_if.tdata), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    @(negedge clk);
    chk("pwr_vld", longint'(m_if.tvalid), 0);
    chk("pwr_dat", longint'(m_if.tdata), 0);
    chk("pwr_rdy", longint'(s_if.tready), 1);
    @(posedge clk); #1;

    // 1 impulse
    run("imp", 8, 0, 0, 0);
    chk_imp("imp", 0);
    // 2 DC
    run("dc", 12, 1, 0, 0);
    chk("dc_re", obs_re[$], 4000);
    chk("dc_im", obs_im[$], -4000);
    // 3 full scale negative
    run("fs", 10, 2, 0, 0);
    chk("fs_re", obs_re[$], -131072);
    chk("fs_im", obs_im[$], -131072);
    // 4 backpressure with DC, impulse and random data
    run("bp_dc", 10, 1, 0, 1);
    chk("bp_dc_re", obs_re[$], 4000);
    run("bp_rnd", 25, 3, 0, 1);
    // 5 underflow gaps
    run("uf", 12, 3, 5, 0);
    base = n_beats;
    repeat (12) @(posedge clk);
    #1;
    chk("uf_no_extra", n_beats, base);
    @(negedge clk);
    chk("uf_vld_low", longint'(m_if.tvalid), 0);
    run("uf_bp", 12, 3, 3, 1);
    @(posedge clk); #1;

    // 6 reset mid-frame at phase 1
    s_if.tdata  = gen(3, 0);
    s_if.tvalid = 1'b1;
    begin
      int guard;
      bit acc;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        acc = s_if.tvalid && s_if.tready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) chk("mrst_acc_timeout", 0, 1);
    end
    rst = 1'b1;
    s_if.tvalid = 1'b0;
    clr_model();
    @(negedge clk);
    chk("mrst_in_rdy", longint'(s_if.tready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_vld", longint'(m_if.tvalid), 0);
    chk("mrst_dat", longint'(m_if.tdata), 0);
    @(posedge clk); #1;
    run("imp2", 8, 0, 0, 0);
    chk_imp("imp2", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
